// File: rtl/fir_resampler_in_pacer.sv
// Input pacer ahead of the polyphase interpolator: buffers a bursty valid/ready stream
// and re-issues samples as one-cycle strobes spaced at least MIN_GAP clocks apart.
module fir_resampler_in_pacer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_GAP    = 32,
    parameter int FILL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_val_i,
    output logic                  data_rdy_o,
    input  logic                  clr_ovf_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_val_o,
    output logic [FILL_WIDTH-1:0] fill_o,
    output logic                  ovf_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [FILL_WIDTH-1:0] FULL       = FILL_WIDTH'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0]      GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_HOLDOFF
    } pacer_state_t;

    pacer_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FILL_WIDTH-1:0] count;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_nxt;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // Readiness comes from the registered count only, so a full FIFO never
    // accepts even when a pop happens in the same cycle.
    assign data_rdy_o = (count != FULL);
    assign fill_o     = count;
    assign wr_en      = data_val_i && data_rdy_o;
    assign drop       = data_val_i && !data_rdy_o;

    always_comb begin
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    gap_nxt = GAP_RELOAD;
                end
            end
            ST_HOLDOFF: begin
                gap_nxt = gap_cnt - GAP_W'(1);
            end
            default: begin
                gap_nxt = '0;
            end
        endcase
        // IDLE is exactly "gap counter expired"; MIN_GAP=1 therefore never leaves IDLE.
        state_nxt = (gap_nxt != '0) ? ST_HOLDOFF : ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_o     <= '0;
            data_val_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            data_val_o <= pop;
            if (pop) begin
                data_o <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + FILL_WIDTH'(1);
                2'b01:   count <= count - FILL_WIDTH'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf_o <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_resampler_in_pacer.sv
// Randomized bench for fir_resampler_in_pacer: a queue/timestamp reference model of the
// default instance plus a MIN_GAP=1 instance checked by direct arithmetic.
module tb_fir_resampler_in_pacer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int GAP   = 32;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [DW-1:0] din  = '0;
    logic          dval = 1'b0;
    logic          clr  = 1'b0;
    logic          data_rdy_o;
    logic [DW-1:0] data_o;
    logic          data_val_o;
    logic [FW-1:0] fill_o;
    logic          ovf_o;

    logic [DW-1:0] din1  = '0;
    logic          dval1 = 1'b0;
    logic          clr1  = 1'b0;
    logic          rdy1;
    logic [DW-1:0] dout1;
    logic          dv1;
    logic [FW-1:0] fill1;
    logic          ovf1;

    fir_resampler_in_pacer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .MIN_GAP   (GAP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (din),
        .data_val_i(dval),
        .data_rdy_o(data_rdy_o),
        .clr_ovf_i (clr),
        .data_o    (data_o),
        .data_val_o(data_val_o),
        .fill_o    (fill_o),
        .ovf_o     (ovf_o)
    );

    fir_resampler_in_pacer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .MIN_GAP   (1)
    ) dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (din1),
        .data_val_i(dval1),
        .data_rdy_o(rdy1),
        .clr_ovf_i (clr1),
        .data_o    (dout1),
        .data_val_o(dv1),
        .fill_o    (fill1),
        .ovf_o     (ovf1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of dut: accepted-sample queue plus the edge index of the last pop.
    logic [DW-1:0] mq[$];
    int            edge_n   = 0;
    int            last_pop = -100000;
    logic          m_val    = 1'b0;
    logic [DW-1:0] m_data   = '0;
    logic          m_ovf    = 1'b0;
    int            n_acc    = 0;
    logic [23:0]   exp_vec;
    logic [23:0]   act_vec;

    task automatic tick();
        int sb;
        bit do_pop;
        bit do_drop;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            mq.delete();
            last_pop = -100000;
            m_val    = 1'b0;
            m_data   = '0;
            m_ovf    = 1'b0;
        end else begin
            sb      = mq.size();
            do_pop  = (sb > 0) && (edge_n - last_pop >= GAP);
            do_drop = dval && (sb >= DEPTH);
            if (do_pop) begin
                m_data   = mq.pop_front();
                m_val    = 1'b1;
                last_pop = edge_n;
            end else begin
                m_val = 1'b0;
            end
            if (dval && !do_drop) begin
                mq.push_back(din);
                n_acc++;
            end
            if (do_drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        #1;
        exp_vec = {m_val, m_data, 5'(mq.size()), (mq.size() != DEPTH), m_ovf};
        act_vec = {data_val_o, data_o, 5'(fill_o), data_rdy_o, ovf_o};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_val_o, data_o, fill_o, ovf_o, data_rdy_o} !== {1'b0, 16'h0, 5'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got val=%b data=%h fill=%0d ovf=%b rdy=%b required 0/0000/0/0/1",
                     data_val_o, data_o, fill_o, ovf_o, data_rdy_o);
        end
        checks++;
        if ({dv1, dout1, fill1, ovf1, rdy1} !== {1'b0, 16'h0, 5'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state_gap1: got val=%b data=%h fill=%0d ovf=%b rdy=%b required 0/0000/0/0/1",
                     dv1, dout1, fill1, ovf1, rdy1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int lat;
        din  = 16'h1234;
        dval = 1'b1;
        tick();
        dval = 1'b0;
        lat  = 1;
        while (!data_val_o && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL single_latency: got %0d edges required 2", lat);
        end
        checks++;
        if (data_o !== 16'h1234) begin
            errors++;
            $display("FAIL single_data: got %h required 1234", data_o);
        end
        tick();
        checks++;
        if ({data_val_o, data_o, fill_o} !== {1'b0, 16'h1234, 5'd0}) begin
            errors++;
            $display("FAIL single_after: got val=%b data=%h fill=%0d required 0/1234/0",
                     data_val_o, data_o, fill_o);
        end
        idle(GAP + 4);
    endtask

    task automatic test_burst();
        int pulse_edge[$];
        logic [DW-1:0] pulse_val[$];
        bit rdy_dropped = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            din  = DW'(i);
            dval = 1'b1;
            tick();
            if (!data_rdy_o) rdy_dropped = 1'b1;
            if (data_val_o) begin
                pulse_edge.push_back(edge_n);
                pulse_val.push_back(data_o);
            end
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL burst_cycle edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        dval = 1'b0;
        for (int c = 0; c < 8 * GAP + 8; c++) begin
            tick();
            if (!data_rdy_o) rdy_dropped = 1'b1;
            if (data_val_o) begin
                pulse_edge.push_back(edge_n);
                pulse_val.push_back(data_o);
            end
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL burst_cycle edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        checks++;
        if (pulse_edge.size() !== 8) begin
            errors++;
            $display("FAIL burst_count: got %0d pulses required 8", pulse_edge.size());
        end
        for (int i = 0; i < pulse_val.size(); i++) begin
            checks++;
            if (pulse_val[i] !== DW'(i + 1)) begin
                errors++;
                $display("FAIL burst_order[%0d]: got %h required %h", i, pulse_val[i], DW'(i + 1));
            end
            if (i > 0) begin
                checks++;
                if (pulse_edge[i] - pulse_edge[i-1] !== GAP) begin
                    errors++;
                    $display("FAIL burst_spacing[%0d]: got %0d required %0d", i,
                             pulse_edge[i] - pulse_edge[i-1], GAP);
                end
            end
        end
        checks++;
        if (rdy_dropped) begin
            errors++;
            $display("FAIL burst_rdy: got data_rdy_o low during burst required 1");
        end
    endtask

    task automatic test_overflow();
        bit saw_not_ready = 1'b0;
        int pulses        = 0;
        int acc0          = n_acc;
        for (int i = 0; i < 20; i++) begin
            din  = DW'($urandom);
            dval = 1'b1;
            tick();
            if (!data_rdy_o) saw_not_ready = 1'b1;
            if (data_val_o) pulses++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL ovf_cycle edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        dval = 1'b0;
        checks++;
        if ({ovf_o, saw_not_ready} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b rdy_fell=%b required 1/1", ovf_o, saw_not_ready);
        end
        for (int c = 0; c < 20 * GAP; c++) begin
            tick();
            if (data_val_o) pulses++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL ovf_drain edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        // From idle: one pop at the 2nd edge, full after the 17th, the last 3 offers dropped.
        checks++;
        if (pulses !== 17 || n_acc - acc0 !== 17) begin
            errors++;
            $display("FAIL ovf_accepted: got %0d pulses (model %0d) required 17", pulses, n_acc - acc0);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", ovf_o);
        end
    endtask

    task automatic test_min_gap1();
        logic [DW-1:0] v[24];
        for (int i = 0; i < 24; i++) begin
            v[i]  = DW'($urandom);
            din1  = v[i];
            dval1 = 1'b1;
            tick();
            checks++;
            if (i == 0) begin
                if ({dv1, fill1, rdy1, ovf1} !== {1'b0, 5'd1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL gap1_first: got val=%b fill=%0d rdy=%b ovf=%b required 0/1/1/0",
                             dv1, fill1, rdy1, ovf1);
                end
            end else if ({dv1, dout1, fill1, rdy1, ovf1} !== {1'b1, v[i-1], 5'd1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL gap1_stream[%0d]: got val=%b data=%h fill=%0d ovf=%b required 1/%h/1/0",
                         i, dv1, dout1, fill1, ovf1, v[i-1]);
            end
        end
        dval1 = 1'b0;
        tick();
        checks++;
        if ({dv1, dout1, fill1} !== {1'b1, v[23], 5'd0}) begin
            errors++;
            $display("FAIL gap1_last: got val=%b data=%h fill=%0d required 1/%h/0", dv1, dout1, fill1, v[23]);
        end
        tick();
        checks++;
        if (dv1 !== 1'b0) begin
            errors++;
            $display("FAIL gap1_idle: got %b required 0", dv1);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s;
        for (int i = 0; i < 11; i++) begin
            din  = DW'($urandom);
            dval = 1'b1;
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL rstmid_fill edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        dval = 1'b0;
        checks++;
        if (fill_o !== 5'd10) begin
            errors++;
            $display("FAIL rstmid_level: got %0d required 10", fill_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({data_val_o, fill_o, data_rdy_o} !== {1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_cleared: got val=%b fill=%0d rdy=%b required 0/0/1", data_val_o, fill_o, data_rdy_o);
        end
        s    = DW'($urandom);
        din  = s;
        dval = 1'b1;
        tick();
        dval = 1'b0;
        checks++;
        if (data_val_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nobypass: got %b required 0", data_val_o);
        end
        tick();
        checks++;
        if ({data_val_o, data_o} !== {1'b1, s}) begin
            errors++;
            $display("FAIL rstmid_first: got val=%b data=%h required 1/%h", data_val_o, data_o, s);
        end
        idle(GAP + 4);
    endtask

    task automatic test_back_to_back();
        int  coincident = 0;
        bit  pop_next;
        bit  offer;
        for (int c = 0; c < 1800 + 17 * GAP; c++) begin
            pop_next = (mq.size() > 0) && (edge_n + 1 - last_pop >= GAP);
            offer    = (c < 1800) && ((mq.size() < DEPTH - 1) || (mq.size() == DEPTH - 1 && pop_next));
            if (offer && mq.size() == DEPTH - 1) coincident++;
            din  = DW'($urandom);
            dval = offer;
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b_cycle edge %0d: got %h required %h", edge_n, act_vec, exp_vec);
            end
        end
        dval = 1'b0;
        checks++;
        if (coincident < 3 * DEPTH) begin
            errors++;
            $display("FAIL b2b_wraps: got %0d coincident write+pop required >= %0d", coincident, 3 * DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_min_gap1();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
